cache_miss_ctrl: RTL and testbench
==================================

# cache_miss_ctrl

Miss-handling sequencer for one cache's data RAM and tag array. It accepts a miss from the pipeline and picks a victim way round-robin. A dirty victim line is written back as a single burst, then the new line is fetched and streamed word-by-word into the data RAM through its write port. The block sits between the cache lookup stage and the bus interface, and it owns the data RAM's write/address inputs whenever a refill is in flight.

## Interface
- LOG_H, 8, log2 of number of sets
- LOG_N, 1, log2 of ways (≥1)
- LOG_W, 2, log2 of 32-bit words per line
- Derived constants:
  - W = 2^LOG_W
  - N = 2^LOG_N
  - TAG_W = 32-LOG_H-LOG_W-2

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- miss_valid  in  1  miss request
- miss_ready  out  1  request accepted when both high
- miss_index  in  LOG_H  set of missing line
- miss_tag  in  TAG_W  tag of missing line
- victim_way  out  LOG_N  current round-robin pointer
- victim_dirty  in  1  dirty bit of (miss_index, victim_way), valid with miss_valid
- victim_tag  in  TAG_W  tag of that way
- dr_we  out  1  data RAM word write enable
- dr_index  out  LOG_H  data RAM set
- dr_way  out  LOG_N  data RAM way
- dr_offset  out  LOG_W  data RAM word
- dr_din  out  32  data RAM write word
- dr_line  in  W*32  combinational whole-line read of (dr_index, dr_way)
- tag_we  out  1  tag-array write strobe
- tag_index  out  LOG_H  tag-array set
- tag_way  out  LOG_N  tag-array way
- tag_wdata  out  TAG_W  tag written (valid=1, dirty=0 implied)
- wr_req  out  1  writeback request
- wr_addr  out  32  writeback address
- wr_data  out  W*32  writeback line
- wr_rdy  in  1  writeback accepted
- rd_req  out  1  refill request
- rd_addr  out  32  refill address
- rd_rdy  in  1  refill request accepted
- ret_valid  in  1  refill data beat
- ret_last  in  1  final beat
- ret_data  in  32  beat data
- refill_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, WB_REQ, RD_REQ, REFILL, DONE.
- **IDLE:**
  - miss_ready = 1.
  - dr_index = miss_index and dr_way = victim_way, combinationally.
  - On acceptance:
    - Latch index, tag, way = victim_way, victim_tag, and dr_line into the writeback buffer.
    - Advance the pointer (mod N).
    - Go to WB_REQ if victim_dirty, else RD_REQ.
- **WB_REQ:**
  - wr_req = 1, wr_addr = {victim_tag, index, LOG_W+2 zeros}, wr_data = buffer.
  - All three are held stable until wr_rdy = 1 in the same cycle; then go to RD_REQ.
- **RD_REQ:**
  - rd_req = 1, rd_addr = {tag, index, zeros}, held until rd_rdy.
  - On rd_rdy, clear the beat counter and go to REFILL.
- **REFILL:** on each ret_valid:
  - dr_we = 1, dr_offset = counter, dr_din = ret_data; counter increments.
  - ret_last moves the block to DONE. The bus delivers exactly W beats.
- **DONE:**
  - refill_done = 1 and tag_we = 1, with tag_index/tag_way/tag_wdata = latched index/way/tag.
  - Next state is IDLE.
- Outside IDLE, dr_index/dr_way/tag_* come from the latched registers.
- The following inputs are ignored outside their own state: miss_valid (outside IDLE), wr_rdy (outside WB_REQ), rd_rdy (outside RD_REQ), ret_valid/ret_last (outside REFILL).
- A 32-bit address split is fixed: tag | index | word offset | byte offset.

## Timing
- Reset (resetn low at a clock edge):
  - State goes to IDLE; pointer and beat counter go to 0.
  - wr_req, rd_req, dr_we, tag_we and refill_done are 0.
  - miss_ready = 0 while resetn is low; it is 1 from the first cycle after release.
- Reset mid-operation abandons the transaction. No tag_we or refill_done is issued, and outstanding bus beats are ignored.
- A miss accepted at cycle T with a clean victim, rd_rdy already high and back-to-back beats:
  - RD_REQ at T+1.
  - Beats written in T+2..T+1+W.
  - DONE at T+2+W.
  - miss_ready again at T+3+W.
- A dirty victim adds the WB_REQ cycles (at least 1).
- dr_we is never asserted outside REFILL. Gaps in ret_valid insert idle cycles with the offset unchanged.
- The writeback buffer is captured at acceptance, so refill writes can never corrupt wr_data.

## Test plan
- **Clean miss:**
  - Stimulus: index 0x12, tag 0xABCDE, victim clean, rd_rdy = 1, beats 0x11, 0x22, 0x33, 0x44.
  - Required: rd_addr = 0xABCDE120; dr writes offsets 0..3 with those words on way 0; tag_we with tag 0xABCDE and refill_done at T+6; miss_ready = 1 at T+7.
- **Dirty miss:**
  - Stimulus: victim_tag 0x00055, dr_line = 0x4444_4444_3333_3333_2222_2222_1111_1111, wr_rdy delayed 3 cycles.
  - Required: wr_req held 4 cycles with wr_addr = 0x00055120 and that wr_data; rd_req first asserted the cycle after the wr_rdy handshake.
- **Round robin:**
  - Stimulus: three consecutive misses (LOG_N = 1).
  - Required: victim_way/dr_way = 0, 1, 0; the pointer returns to 0 after reset.
- **Bubbled return:**
  - Stimulus: ret_valid pattern 1, 0, 0, 1, 1, 0, 1.
  - Required: exactly 4 dr_we pulses at offsets 0, 1, 2, 3; DONE the cycle after the 4th beat.
- **Reset mid-refill:**
  - Stimulus: resetn low after 2 beats.
  - Required: the next cycle shows dr_we = 0, no tag_we and no refill_done; miss_ready = 1 after release; victim_way = 0.
- **Held miss_valid:**
  - Stimulus: miss_valid held high through a whole refill.
  - Required: exactly one acceptance per IDLE cycle; the second miss is accepted at the first IDLE cycle after DONE.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer: picks a victim way round-robin, writes a dirty victim back as one
// burst, then streams the refill into the data RAM and updates the tag array.
module cache_miss_ctrl #(
   parameter int  LOG_H = 8,
   parameter int  LOG_N = 1,
   parameter int  LOG_W = 2,
   localparam int W     = 1 << LOG_W,
   localparam int TAG_W = 32 - LOG_H - LOG_W - 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               miss_valid,
   output logic               miss_ready,
   input  logic [LOG_H-1:0]   miss_index,
   input  logic [TAG_W-1:0]   miss_tag,
   output logic [LOG_N-1:0]   victim_way,
   input  logic               victim_dirty,
   input  logic [TAG_W-1:0]   victim_tag,
   output logic               dr_we,
   output logic [LOG_H-1:0]   dr_index,
   output logic [LOG_N-1:0]   dr_way,
   output logic [LOG_W-1:0]   dr_offset,
   output logic [31:0]        dr_din,
   input  logic [W*32-1:0]    dr_line,
   output logic               tag_we,
   output logic [LOG_H-1:0]   tag_index,
   output logic [LOG_N-1:0]   tag_way,
   output logic [TAG_W-1:0]   tag_wdata,
   output logic               wr_req,
   output logic [31:0]        wr_addr,
   output logic [W*32-1:0]    wr_data,
   input  logic               wr_rdy,
   output logic               rd_req,
   output logic [31:0]        rd_addr,
   input  logic               rd_rdy,
   input  logic               ret_valid,
   input  logic               ret_last,
   input  logic [31:0]        ret_data,
   output logic               refill_done
);

   localparam int OFS_W = LOG_W + 2;

   typedef enum logic [2:0] {IDLE, WB_REQ, RD_REQ, REFILL, DONE} state_t;

   state_t             state, state_nx;
   logic [LOG_N-1:0]   ptr;
   logic [LOG_W-1:0]   cnt;
   logic [LOG_H-1:0]   idx_q;
   logic [TAG_W-1:0]   tag_q;
   logic [TAG_W-1:0]   vtag_q;
   logic [LOG_N-1:0]   way_q;
   logic [W*32-1:0]    buf_q;
   logic               accept;

   assign miss_ready = resetn && (state == IDLE);
   assign accept     = miss_valid && miss_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            ptr <= ptr + LOG_N'(1);
         end
         if (state == RD_REQ && rd_rdy) begin
            cnt <= '0;
         end else if (state == REFILL && ret_valid) begin
            cnt <= cnt + LOG_W'(1);
         end
      end
   end

   // Victim line is snapshotted at acceptance so refill writes cannot disturb wr_data.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q  <= miss_index;
         tag_q  <= miss_tag;
         way_q  <= ptr;
         vtag_q <= victim_tag;
         buf_q  <= dr_line;
      end
   end

   assign victim_way = ptr;
   assign dr_offset  = cnt;
   assign dr_din     = ret_data;
   assign tag_index  = idx_q;
   assign tag_way    = way_q;
   assign tag_wdata  = tag_q;
   assign wr_addr    = {vtag_q, idx_q, {OFS_W{1'b0}}};
   assign wr_data    = buf_q;
   assign rd_addr    = {tag_q, idx_q, {OFS_W{1'b0}}};

   always_comb begin
      state_nx    = state;
      dr_we       = 1'b0;
      wr_req      = 1'b0;
      rd_req      = 1'b0;
      tag_we      = 1'b0;
      refill_done = 1'b0;
      dr_index    = idx_q;
      dr_way      = way_q;
      case (state)
         IDLE: begin
            dr_index = miss_index;
            dr_way   = ptr;
            if (accept) begin
               state_nx = victim_dirty ? WB_REQ : RD_REQ;
            end
         end
         WB_REQ: begin
            wr_req = 1'b1;
            if (wr_rdy) begin
               state_nx = RD_REQ;
            end
         end
         RD_REQ: begin
            rd_req = 1'b1;
            if (rd_rdy) begin
               state_nx = REFILL;
            end
         end
         REFILL: begin
            dr_we = ret_valid;
            if (ret_valid && ret_last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            tag_we      = 1'b1;
            refill_done = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: scripted and randomized misses against a line-level model
// of the data RAM, the round-robin pointer and the bus address arithmetic.
module tb_cache_miss_ctrl;
   localparam int LOG_H = 8;
   localparam int LOG_N = 1;
   localparam int LOG_W = 2;
   localparam int W     = 1 << LOG_W;
   localparam int N     = 1 << LOG_N;
   localparam int SETS  = 1 << LOG_H;
   localparam int TAG_W = 32 - LOG_H - LOG_W - 2;
   localparam int SH    = LOG_W + 2;

   logic               clk;
   logic               resetn;
   logic               miss_valid;
   logic               miss_ready;
   logic [LOG_H-1:0]   miss_index;
   logic [TAG_W-1:0]   miss_tag;
   logic [LOG_N-1:0]   victim_way;
   logic               victim_dirty;
   logic [TAG_W-1:0]   victim_tag;
   logic               dr_we;
   logic [LOG_H-1:0]   dr_index;
   logic [LOG_N-1:0]   dr_way;
   logic [LOG_W-1:0]   dr_offset;
   logic [31:0]        dr_din;
   logic [W*32-1:0]    dr_line;
   logic               tag_we;
   logic [LOG_H-1:0]   tag_index;
   logic [LOG_N-1:0]   tag_way;
   logic [TAG_W-1:0]   tag_wdata;
   logic               wr_req;
   logic [31:0]        wr_addr;
   logic [W*32-1:0]    wr_data;
   logic               wr_rdy;
   logic               rd_req;
   logic [31:0]        rd_addr;
   logic               rd_rdy;
   logic               ret_valid;
   logic               ret_last;
   logic [31:0]        ret_data;
   logic               refill_done;

   int n_cmp = 0;
   int n_err = 0;
   int exp_ptr = 0;

   // Environment RAM (written by the DUT) and the bench's own expected contents.
   logic [W*32-1:0] ram [SETS][N];
   logic [W*32-1:0] mdl [SETS][N];
   bit              known [SETS][N];
   logic               pre_we;
   logic [LOG_H-1:0]   pre_i;
   logic [LOG_N-1:0]   pre_w;
   logic [W*32-1:0]    pre_line;

   cache_miss_ctrl #(.LOG_H(LOG_H), .LOG_N(LOG_N), .LOG_W(LOG_W)) dut (
      .clk(clk), .resetn(resetn),
      .miss_valid(miss_valid), .miss_ready(miss_ready),
      .miss_index(miss_index), .miss_tag(miss_tag),
      .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
      .dr_we(dr_we), .dr_index(dr_index), .dr_way(dr_way), .dr_offset(dr_offset),
      .dr_din(dr_din), .dr_line(dr_line),
      .tag_we(tag_we), .tag_index(tag_index), .tag_way(tag_way), .tag_wdata(tag_wdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .refill_done(refill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) ram[pre_i][pre_w] <= pre_line;
      else if (dr_we) ram[dr_index][dr_way][int'(dr_offset)*32 +: 32] <= dr_din;
   end

   assign dr_line = ram[dr_index][dr_way];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [LOG_H-1:0] i, input int w, input logic [W*32-1:0] line);
      pre_i = i; pre_w = LOG_N'(w); pre_line = line; pre_we = 1'b1;
      tick();
      pre_we = 1'b0;
      mdl[i][w] = line;
      known[i][w] = 1'b1;
   endtask

   task automatic noise();
      wr_rdy = 1'($urandom); rd_rdy = 1'($urandom);
      ret_valid = 1'($urandom); ret_last = 1'($urandom); ret_data = $urandom;
   endtask

   // One complete miss; abort_after >= 0 pulls reset after that many beats.
   task automatic run_miss(input logic [LOG_H-1:0] idx, input logic [TAG_W-1:0] tag,
                           input logic dirty, input logic [TAG_W-1:0] vtag,
                           input int wb_delay, input int rd_delay,
                           input logic [15:0] vpat, input int vlen,
                           input logic hold, input int abort_after, input logic [31:0] data0);
      int way, k, cyc, pulses;
      logic v;
      logic [31:0] d, exp_wa, exp_ra;
      logic [W*32-1:0] exp_line;
      way      = exp_ptr;
      exp_line = mdl[idx][way];
      exp_wa   = (32'(vtag) << (LOG_H + SH)) | (32'(idx) << SH);
      exp_ra   = (32'(tag) << (LOG_H + SH)) | (32'(idx) << SH);

      noise();
      miss_valid = 1'b1; miss_index = idx; miss_tag = tag;
      victim_dirty = dirty; victim_tag = vtag;
      #1;
      n_cmp++;
      if (miss_ready !== 1'b1) begin
         n_err++; $display("FAIL idle_ready: got %b want 1", miss_ready);
      end
      n_cmp++;
      if (victim_way !== LOG_N'(way) || dr_way !== LOG_N'(way) || dr_index !== idx) begin
         n_err++;
         $display("FAIL idle_victim: victim_way=%0d dr_way=%0d dr_index=%h want way %0d index %h",
                  victim_way, dr_way, dr_index, way, idx);
      end
      tick();
      exp_ptr = (exp_ptr + 1) % N;
      if (!hold) miss_valid = 1'b0;

      if (dirty) begin
         for (int c = 0; c <= wb_delay; c++) begin
            noise();
            wr_rdy = (c == wb_delay);
            #1;
            n_cmp++;
            if (wr_req !== 1'b1 || wr_addr !== exp_wa || wr_data !== exp_line) begin
               n_err++;
               $display("FAIL wb_req: req=%b addr=%h data=%h want 1 %h %h",
                        wr_req, wr_addr, wr_data, exp_wa, exp_line);
            end
            n_cmp++;
            if (rd_req !== 1'b0 || dr_we !== 1'b0 || miss_ready !== 1'b0 ||
                victim_way !== LOG_N'(exp_ptr)) begin
               n_err++;
               $display("FAIL wb_side: rd_req=%b dr_we=%b ready=%b victim_way=%0d want 0 0 0 %0d",
                        rd_req, dr_we, miss_ready, victim_way, exp_ptr);
            end
            tick();
         end
      end

      for (int c = 0; c <= rd_delay; c++) begin
         noise();
         rd_rdy = (c == rd_delay);
         #1;
         n_cmp++;
         if (rd_req !== 1'b1 || rd_addr !== exp_ra) begin
            n_err++;
            $display("FAIL rd_req: req=%b addr=%h want 1 %h", rd_req, rd_addr, exp_ra);
         end
         n_cmp++;
         if (wr_req !== 1'b0 || dr_we !== 1'b0 || miss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rd_side: wr_req=%b dr_we=%b ready=%b want 0 0 0", wr_req, dr_we, miss_ready);
         end
         tick();
      end

      k = 0; cyc = 0; pulses = 0;
      while (k < W) begin
         v = (cyc < vlen) ? vpat[cyc] : 1'b1;
         d = (data0 != 0) ? data0 * 32'(k + 1) : $urandom;
         rd_rdy = 1'($urandom); wr_rdy = 1'($urandom);
         ret_valid = v; ret_last = v && (k == W - 1); ret_data = d;
         if (k == abort_after) begin
            miss_valid = 1'b0;
            ret_valid = 1'b1; ret_last = 1'b0;
            resetn = 1'b0;
            tick();
            n_cmp++;
            if (dr_we !== 1'b0 || tag_we !== 1'b0 || refill_done !== 1'b0 || miss_ready !== 1'b0) begin
               n_err++;
               $display("FAIL abort_reset: dr_we=%b tag_we=%b done=%b ready=%b want 0 0 0 0",
                        dr_we, tag_we, refill_done, miss_ready);
            end
            resetn = 1'b1;
            exp_ptr = 0;
            known[idx][way] = 1'b0;
            for (int c = 0; c < 3; c++) begin
               ret_valid = 1'b1; ret_last = 1'($urandom); ret_data = $urandom;
               #1;
               n_cmp++;
               if (dr_we !== 1'b0 || tag_we !== 1'b0 || refill_done !== 1'b0 ||
                   miss_ready !== 1'b1 || victim_way !== '0 || rd_req !== 1'b0 || wr_req !== 1'b0) begin
                  n_err++;
                  $display("FAIL abort_after_release: dr_we=%b tag_we=%b done=%b ready=%b way=%0d want 0 0 0 1 0",
                           dr_we, tag_we, refill_done, miss_ready, victim_way);
               end
               tick();
            end
            ret_valid = 1'b0; ret_last = 1'b0;
            return;
         end
         #1;
         n_cmp++;
         if (dr_we !== v) begin
            n_err++; $display("FAIL refill_we: cyc %0d got %b want %b", cyc, dr_we, v);
         end
         if (v) begin
            n_cmp++;
            if (dr_offset !== LOG_W'(k) || dr_din !== d || dr_index !== idx || dr_way !== LOG_N'(way)) begin
               n_err++;
               $display("FAIL refill_beat: off=%0d din=%h idx=%h way=%0d want %0d %h %h %0d",
                        dr_offset, dr_din, dr_index, dr_way, k, d, idx, way);
            end
         end
         n_cmp++;
         if (tag_we !== 1'b0 || refill_done !== 1'b0 || rd_req !== 1'b0 ||
             wr_req !== 1'b0 || miss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL refill_side: tag_we=%b done=%b rd=%b wr=%b ready=%b want all 0",
                     tag_we, refill_done, rd_req, wr_req, miss_ready);
         end
         if (dr_we === 1'b1) pulses++;
         tick();
         if (v) begin
            mdl[idx][way][k*32 +: 32] = d;
            k++;
         end
         cyc++;
      end
      n_cmp++;
      if (pulses != W) begin
         n_err++; $display("FAIL beat_count: got %0d want %0d", pulses, W);
      end

      noise();
      #1;
      n_cmp++;
      if (refill_done !== 1'b1 || tag_we !== 1'b1 || tag_index !== idx ||
          tag_way !== LOG_N'(way) || tag_wdata !== tag) begin
         n_err++;
         $display("FAIL done_tag: done=%b we=%b idx=%h way=%0d tag=%h want 1 1 %h %0d %h",
                  refill_done, tag_we, tag_index, tag_way, tag_wdata, idx, way, tag);
      end
      n_cmp++;
      if (dr_we !== 1'b0 || miss_ready !== 1'b0) begin
         n_err++; $display("FAIL done_side: dr_we=%b ready=%b want 0 0", dr_we, miss_ready);
      end
      tick();
      known[idx][way] = 1'b1;
      ret_valid = 1'b0; ret_last = 1'b0;
      if (!hold) begin
         n_cmp++;
         if (miss_ready !== 1'b1 || refill_done !== 1'b0 || tag_we !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_idle: ready=%b done=%b tag_we=%b want 1 0 0",
                     miss_ready, refill_done, tag_we);
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      miss_valid = 1'b1;
      noise();
      tick();
      tick();
      n_cmp++;
      if (miss_ready !== 1'b0 || wr_req !== 1'b0 || rd_req !== 1'b0 ||
          dr_we !== 1'b0 || tag_we !== 1'b0 || refill_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: ready=%b wr=%b rd=%b we=%b tag_we=%b done=%b want all 0",
                  miss_ready, wr_req, rd_req, dr_we, tag_we, refill_done);
      end
      miss_valid = 1'b0;
      resetn = 1'b1;
      exp_ptr = 0;
      #1;
      n_cmp++;
      if (miss_ready !== 1'b1 || victim_way !== '0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b way=%0d want 1 0", miss_ready, victim_way);
      end
      tick();
   endtask

   task automatic test_clean_miss();
      run_miss(8'h12, 20'hABCDE, 1'b0, TAG_W'($urandom), 0, 0, 16'hFFFF, 0, 1'b0, -1, 32'h11);
      n_cmp++;
      if (ram[8'h12][0] !== 128'h00000044_00000033_00000022_00000011) begin
         n_err++; $display("FAIL clean_line: got %h want 00000044000000330000002200000011", ram[8'h12][0]);
      end
   endtask

   task automatic test_dirty_miss();
      preload(8'h12, exp_ptr, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
      run_miss(8'h12, TAG_W'($urandom), 1'b1, 20'h00055, 3, 0, 16'hFFFF, 0, 1'b0, -1, 32'h0);
   endtask

   task automatic test_round_robin();
      logic [LOG_N-1:0] seq [3];
      seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0;
      test_reset();
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (victim_way !== seq[i]) begin
            n_err++; $display("FAIL round_robin: miss %0d way=%0d want %0d", i, victim_way, seq[i]);
         end
         run_miss(LOG_H'($urandom), TAG_W'($urandom), 1'b0, TAG_W'($urandom), 0, 0,
                  16'hFFFF, 0, 1'b0, -1, 32'h0);
      end
   endtask

   task automatic test_bubbled_return();
      run_miss(8'h5A, TAG_W'($urandom), 1'b0, TAG_W'($urandom), 0, 1,
               16'b0000_0000_0101_1001, 7, 1'b0, -1, 32'h0);
   endtask

   task automatic test_reset_mid_refill();
      if (exp_ptr == 0)
         run_miss(8'h01, TAG_W'($urandom), 1'b0, TAG_W'($urandom), 0, 0, 16'hFFFF, 0, 1'b0, -1, 32'h0);
      run_miss(8'h33, TAG_W'($urandom), 1'b0, TAG_W'($urandom), 0, 0, 16'hFFFF, 0, 1'b0, 2, 32'h0);
   endtask

   task automatic test_held_valid();
      run_miss(8'h40, TAG_W'($urandom), 1'b1, TAG_W'($urandom), 1, 0, 16'hFFFF, 0, 1'b1, -1, 32'h0);
      run_miss(8'h41, TAG_W'($urandom), 1'b0, TAG_W'($urandom), 0, 2, 16'hFFFF, 0, 1'b1, -1, 32'h0);
      run_miss(8'h40, TAG_W'($urandom), 1'b1, TAG_W'($urandom), 0, 0, 16'hFFFF, 0, 1'b0, -1, 32'h0);
   endtask

   task automatic test_random();
      logic [LOG_H-1:0] idx;
      logic             dirty;
      for (int i = 0; i < 30; i++) begin
         idx   = LOG_H'($urandom_range(0, 3));
         dirty = 1'($urandom);
         if (dirty && !known[idx][exp_ptr])
            preload(idx, exp_ptr, {$urandom, $urandom, $urandom, $urandom});
         run_miss(idx, TAG_W'($urandom), dirty, TAG_W'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  16'($urandom), $urandom_range(0, 10), 1'b0, -1, 32'h0);
      end
   endtask

   initial begin
      resetn = 1'b0; miss_valid = 1'b0; miss_index = '0; miss_tag = '0;
      victim_dirty = 1'b0; victim_tag = '0; wr_rdy = 1'b0; rd_rdy = 1'b0;
      ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0; pre_we = 1'b0;
      pre_i = '0; pre_w = '0; pre_line = '0;
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_round_robin();
      test_bubbled_return();
      test_reset_mid_refill();
      test_held_valid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
